// File: rtl/uart_txq_pkg.sv
// Shared definitions for the UART transmit queue: register map, bit
// positions and the bus-side FSM state encoding.
package uart_txq_pkg;

    localparam logic [31:0] REG_RXDT = 32'h0;
    localparam logic [31:0] REG_TXDT = 32'h4;
    localparam logic [31:0] REG_CTRL = 32'h8;
    localparam logic [31:0] REG_STAT = 32'hc;

    localparam int CTRL_TX_EN   = 1;
    localparam int STAT_TX_BUSY = 1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        POLL = 2'd2,
        PUSH = 2'd3
    } state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with combinational head read so the head byte can be placed on
// the bus in the same cycle it is popped.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is refused even if a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/uart_txq.sv
// UART transmit queue: buffers bytes and feeds them to a memory-mapped UART
// over a request/grant peripheral bus, polling the busy flag between bytes.
module uart_txq
    import uart_txq_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] UART_BASE = 32'hffff0020
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic                   bus_we,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wdata,
    input  logic [31:0]            bus_rdata,
    output logic [$clog2(DEPTH):0] fifo_count
);

    state_t      state_reg;
    state_t      state_next;
    logic        req_c;
    logic        we_c;
    logic [31:0] addr_c;
    logic [31:0] wdata_c;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  head_byte;
    logic        unused_rdata;

    assign unused_rdata = ^bus_rdata;

    assign fifo_pop = (state_reg == PUSH) && bus_gnt;
    assign in_ready = !fifo_full;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (head_byte),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        case (state_reg)
            INIT: begin
                req_c = 1'b1;
                if (bus_gnt) begin
                    we_c       = 1'b1;
                    addr_c     = UART_BASE + REG_CTRL;
                    wdata_c    = 32'd1 << CTRL_TX_EN;
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = POLL;
                end
            end
            POLL: begin
                req_c = 1'b1;
                if (bus_gnt) begin
                    addr_c = UART_BASE + REG_STAT;
                    if (!bus_rdata[STAT_TX_BUSY]) begin
                        state_next = PUSH;
                    end
                end
            end
            PUSH: begin
                req_c = 1'b1;
                if (bus_gnt) begin
                    we_c       = 1'b1;
                    addr_c     = UART_BASE + REG_TXDT;
                    wdata_c    = {24'b0, head_byte};
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // The bus must read as idle while reset is held, even though state is INIT.
    assign bus_req   = req_c && !rst;
    assign bus_we    = we_c && !rst;
    assign bus_addr  = rst ? 32'h0 : addr_c;
    assign bus_wdata = rst ? 32'h0 : wdata_c;

endmodule

// File: tb/tb_uart_txq.sv
// Directed testbench for uart_txq: bus protocol, FIFO ordering and reset.
module tb_uart_txq;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hffff0020;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;
    logic [63:0] wr_log[$];

    uart_txq #(
        .DEPTH(DEPTH),
        .UART_BASE(BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed bus write as {addr, data}.
    always @(posedge clk) begin
        if (!rst && bus_req && bus_gnt && bus_we) begin
            wr_log.push_back({bus_addr, bus_wdata});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; bus_gnt = 1'b1; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we: got %b expected 0", bus_we); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 00000000", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h expected 00000000", bus_wdata); end
        $display("test_reset done");
    endtask

    task automatic test_ctrl_init();
        wr_log.delete();
        rst = 1'b0;
        #1;
        checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL init_we: got %b expected 1", bus_we); end
        checks++; if (bus_addr !== 32'hffff0028) begin errors++; $display("FAIL init_addr: got %h expected ffff0028", bus_addr); end
        checks++; if (bus_wdata !== 32'h2) begin errors++; $display("FAIL init_wdata: got %h expected 00000002", bus_wdata); end
        @(negedge clk); #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL init_idle_req: got %b expected 0", bus_req); end
        checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL init_log_size: got %0d expected 1", wr_log.size()); end
        $display("test_ctrl_init done");
    endtask

    task automatic test_poll_busy();
        int n;
        wr_log.delete();
        bus_gnt = 1'b1; bus_rdata = 32'h2;
        in_valid = 1'b1; in_data = 8'h41;
        @(negedge clk); #1;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL poll_count1: got %0d expected 1", fifo_count); end
        n = 0;
        while (!(bus_req === 1'b1 && bus_addr === BASE + 32'hc) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (n >= 20) begin errors++; $display("FAIL poll_reach: got timeout expected POLL within 20 cycles"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus_addr !== BASE + 32'hc || bus_we !== 1'b0) begin errors++; $display("FAIL poll_hold%0d: got addr %h we %b expected ffff002c we 0", i, bus_addr, bus_we); end
            @(negedge clk); #1;
        end
        bus_rdata = 32'h0;
        #1;
        checks++; if (bus_addr !== 32'hffff002c) begin errors++; $display("FAIL poll_last: got %h expected ffff002c", bus_addr); end
        @(negedge clk); #1;
        checks++; if (bus_we !== 1'b1 || bus_addr !== 32'hffff0024 || bus_wdata !== 32'h41) begin errors++; $display("FAIL poll_txdt: got we %b addr %h data %h expected 1 ffff0024 00000041", bus_we, bus_addr, bus_wdata); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL poll_count_before_pop: got %0d expected 1", fifo_count); end
        @(negedge clk); #1;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL poll_count0: got %0d expected 0", fifo_count); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL poll_idle_req: got %b expected 0", bus_req); end
        $display("test_poll_busy done");
    endtask

    task automatic test_fill_order();
        int n;
        logic [63:0] exp_w;
        logic [63:0] got_w;
        wr_log.delete();
        bus_gnt = 1'b1; bus_rdata = 32'h2;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b expected 1", i, in_ready); end
            @(negedge clk); #1;
        end
        in_data = 8'h08;
        checks++; if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d ready %b expected 8 0", fifo_count, in_ready); end
        repeat (2) begin @(negedge clk); #1; end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_ninth_ignored: got %0d expected 8", fifo_count); end
        bus_rdata = 32'h0;
        @(negedge clk); #1;
        checks++; if (bus_we !== 1'b1 || bus_addr !== 32'hffff0024 || bus_wdata !== 32'h0) begin errors++; $display("FAIL fill_first_tx: got we %b addr %h data %h expected 1 ffff0024 00000000", bus_we, bus_addr, bus_wdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_on_pop: got %b expected 0", in_ready); end
        @(negedge clk); #1;
        checks++; if (fifo_count !== 4'd7 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_after_pop: got count %0d ready %b expected 7 1", fifo_count, in_ready); end
        @(negedge clk); #1;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_refill: got %0d expected 8", fifo_count); end
        n = 0;
        while (fifo_count !== 4'd0 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL fill_drain: got count %0d expected 0 within 200 cycles", fifo_count); end
        checks++; if (wr_log.size() !== 9) begin errors++; $display("FAIL fill_log_size: got %0d expected 9", wr_log.size()); end
        for (int i = 0; i < 9; i++) begin
            exp_w = {BASE + 32'h4, 24'h0, 8'(i)};
            got_w = (i < wr_log.size()) ? wr_log[i] : 64'hx;
            checks++; if (got_w !== exp_w) begin errors++; $display("FAIL fill_order%0d: got %h expected %h", i, got_w, exp_w); end
        end
        $display("test_fill_order done");
    endtask

    task automatic test_gnt_drop();
        int n;
        wr_log.delete();
        bus_gnt = 1'b1; bus_rdata = 32'h0;
        in_valid = 1'b1; in_data = 8'h5a;
        @(negedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!(bus_req === 1'b1 && bus_addr === BASE + 32'hc) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (n >= 20) begin errors++; $display("FAIL drop_reach_poll: got timeout expected POLL within 20 cycles"); end
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus_gnt = 1'b0;
            #1;
            checks++; if (bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_req !== 1'b1) begin errors++; $display("FAIL drop_hold%0d: got req %b we %b addr %h data %h expected 1 0 0 0", i, bus_req, bus_we, bus_addr, bus_wdata); end
            checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL drop_count%0d: got %0d expected 1", i, fifo_count); end
            @(negedge clk); #1;
        end
        bus_gnt = 1'b1;
        #1;
        checks++; if (bus_we !== 1'b1 || bus_addr !== 32'hffff0024 || bus_wdata !== 32'h5a) begin errors++; $display("FAIL drop_write: got we %b addr %h data %h expected 1 ffff0024 0000005a", bus_we, bus_addr, bus_wdata); end
        @(negedge clk); #1;
        checks++; if (fifo_count !== 4'd0 || wr_log.size() !== 1) begin errors++; $display("FAIL drop_done: got count %0d writes %0d expected 0 1", fifo_count, wr_log.size()); end
        $display("test_gnt_drop done");
    endtask

    task automatic test_reset_mid();
        logic [63:0] got_w;
        bus_gnt = 1'b1; bus_rdata = 32'h2;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            @(negedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL rmid_count4: got %0d expected 4", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (fifo_count !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_flush: got count %0d ready %b expected 0 1", fifo_count, in_ready); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL rmid_bus: got req %b we %b addr %h data %h expected all 0", bus_req, bus_we, bus_addr, bus_wdata); end
        repeat (2) begin @(negedge clk); #1; end
        bus_gnt = 1'b0; bus_rdata = 32'h0;
        wr_log.delete();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk); #1;
        in_valid = 1'b0;
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL rmid_init_wait: got req %b we %b expected 1 0", bus_req, bus_we); end
        repeat (2) begin @(negedge clk); #1; end
        bus_gnt = 1'b1;
        repeat (20) begin @(negedge clk); #1; end
        checks++; if (wr_log.size() !== 2) begin errors++; $display("FAIL rmid_log_size: got %0d expected 2", wr_log.size()); end
        got_w = (wr_log.size() > 0) ? wr_log[0] : 64'hx;
        checks++; if (got_w !== {BASE + 32'h8, 32'h2}) begin errors++; $display("FAIL rmid_first_ctrl: got %h expected ffff002800000002", got_w); end
        got_w = (wr_log.size() > 1) ? wr_log[1] : 64'hx;
        checks++; if (got_w !== {BASE + 32'h4, 32'h77}) begin errors++; $display("FAIL rmid_then_txdt: got %h expected ffff002400000077", got_w); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_ctrl_init();
        test_poll_busy();
        test_fill_order();
        test_gnt_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_txq.md
UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, byte FIFO depth, power of two, at least 2.
REQ-002 SHALL have parameter UART_BASE, default 32'hffff0020, UART register base address.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, producer presents a byte.
REQ-006 SHALL have port in_data, input, 8 bits, byte to transmit.
REQ-007 SHALL have port in_ready, output, 1 bit, FIFO can accept a byte.
REQ-008 SHALL have port bus_req, output, 1 bit, requests the peripheral bus.
REQ-009 SHALL have port bus_gnt, input, 1 bit, bus granted this cycle.
REQ-010 SHALL have port bus_we, output, 1 bit, write strobe to the UART.
REQ-011 SHALL have port bus_addr, output, 32 bits, UART register address.
REQ-012 SHALL have port bus_wdata, output, 32 bits, write data; the SoC top muxes it onto the shared data bus.
REQ-013 SHALL have port bus_rdata, input, 32 bits, combinational read data from the UART.
REQ-014 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits, bytes queued.

Function
REQ-015 FIFO push SHALL occur on an edge where in_valid and in_ready are both 1; in_ready SHALL equal (fifo_count != DEPTH).
REQ-016 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve byte order; pointers SHALL wrap modulo DEPTH.
REQ-017 When full, in_ready SHALL be 0 even if a pop occurs that cycle.
REQ-018 The FSM SHALL have states INIT, IDLE, POLL and PUSH.
REQ-019 INIT: bus_req=1; on a cycle with bus_gnt=1, drive bus_we=1, bus_addr=UART_BASE+8 and bus_wdata=32'h2 (TX enable), then go to IDLE.
REQ-020 IDLE: bus_req=0; if fifo_count != 0, go to POLL at the next edge.
REQ-021 POLL: bus_req=1; on a cycle with bus_gnt=1, drive bus_we=0 and bus_addr=UART_BASE+'hc, and sample bus_rdata[1] at that edge.
REQ-022 POLL: if the sampled bus_rdata[1] is 0, go to PUSH; otherwise remain in POLL.
REQ-023 PUSH: bus_req=1; on a cycle with bus_gnt=1, drive bus_we=1, bus_addr=UART_BASE+4 and bus_wdata={24'b0, head byte}.
REQ-024 PUSH: on that granted edge, pop the FIFO and go to IDLE.
REQ-025 The block SHALL never write the STAT register.
REQ-026 bus_we, bus_addr and bus_wdata SHALL be a combinational decode of state and bus_gnt; all three SHALL be 0 whenever bus_gnt=0 or bus_req=0.
REQ-027 Loss of bus_gnt in any state SHALL hold the state and perform no FIFO pop.
REQ-028 Minimum byte-to-byte spacing SHALL be 3 cycles (PUSH, IDLE, POLL), gated by UART busy.
REQ-029 fifo_count SHALL saturate at neither bound; overflow and underflow are prevented by in_ready and the state guards.

Reset
REQ-030 While rst=1: state=INIT, FIFO empty, fifo_count=0, in_ready=1, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
REQ-031 Reset mid-operation SHALL discard queued bytes; after release, CTRL SHALL be rewritten before any TXDT write.

Structure
REQ-032 A shared package SHALL hold the UART register offsets (RXDT 0, TXDT 4, CTRL 8, STAT c), CTRL_TX_EN bit 1, STAT_TX_BUSY bit 1, and the FSM state encoding.
REQ-033 The FIFO SHALL be a sub-module named uart_byte_fifo with push/pop/full/empty/count ports; the FSM and bus decode SHALL stay in uart_txq.

Verification
REQ-034 Release reset with bus_gnt=1 -> first granted cycle shows bus_we=1, addr ffff0028, wdata 00000002; no TXDT write before it.
REQ-035 Push 0x41 while bus_rdata[1]=1 for 5 cycles, then 0 -> stays in POLL 5 cycles, then writes ffff0024 with 00000041; fifo_count goes 1 to 0.
REQ-036 Push 8 bytes 0x00..0x07 with UART held busy -> in_ready=0 at count 8; a 9th push is ignored; bytes later transmitted 0x00..0x07 in order.
REQ-037 Full FIFO, in_valid=1 on the pop cycle -> push rejected; next cycle count=7 and push accepted.
REQ-038 Drop bus_gnt during PUSH for 3 cycles -> bus_we=0, no pop; write completes on the first granted cycle.
REQ-039 Assert rst with 4 bytes queued -> count=0 immediately, bus outputs 0; after release, CTRL write precedes any TXDT write.
